// File: rtl/afifo_pkg.sv
// Purpose: shared pointer encode/decode and sizing helpers for both async FIFO clock domains.
// Latency: pure functions and constants, no state.
// Backpressure: none; the values are used by the pointer handlers on either side.
package afifo_pkg;

    // Default pointer width; handlers that take their own PTR_WIDTH use the helpers below.
    localparam int unsigned AFIFO_PTR_WIDTH = 4;

    // Pointer type shared by the read-pointer and write-pointer handlers.
    typedef logic [AFIFO_PTR_WIDTH-1:0] ptr_t;

    // Helper working width. Callers zero-extend into it and size-cast the result
    // back down, so a single function body serves every pointer width.
    localparam int unsigned CODE_W = 32;
    typedef logic [CODE_W-1:0] code_t;

    // FIFO depth for a pointer that carries one extra wrap bit.
    function automatic int unsigned depth_of(input int unsigned ptr_width);
        return 32'd1 << (ptr_width - 1);
    endfunction

    // Binary to Gray: exactly one bit changes per increment.
    function automatic code_t bin2gray(input code_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary, MSB down: bin[MSB] = g[MSB], bin[i] = bin[i+1] ^ g[i].
    // Zero-extended upper bits stay zero, so the low bits decode exactly as a
    // PTR_WIDTH-wide decode would.
    function automatic code_t gray2bin(input code_t g);
        code_t b;
        b = '0;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_sync.sv
// Purpose: generic STAGES-deep, WIDTH-wide reset-to-zero multi-flop synchronizer.
// Latency: a value sampled at edge t appears on q after edge t+STAGES-1.
// Backpressure: none; it samples every clock, so a Gray-coded input is expected.
module afifo_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Plain flop chain with no logic between stages. Only stage[0] sees the asynchronous input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/rd_wptr_sync_decode.sv
// Purpose: bring the Gray write pointer into read_clock, decode it and derive occupancy and status.
// Latency: g_wptr to g_wptr_sync SYNC_STAGES-1 edges after sampling; b_wptr_sync +1; rd_count +1.
// Backpressure: none; status only. Occupancy lags the truth, so almost_empty errs on the safe side.
module rd_wptr_sync_decode
    import afifo_pkg::*;
#(
    parameter int unsigned PTR_WIDTH    = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AE_THRESHOLD = 1
) (
    input  logic                 read_clock,
    input  logic                 read_reset,
    input  logic [PTR_WIDTH-1:0] g_wptr,
    input  logic [PTR_WIDTH-1:0] b_rptr,
    input  logic                 err_clear,
    output logic [PTR_WIDTH-1:0] g_wptr_sync,
    output logic [PTR_WIDTH-1:0] b_wptr_sync,
    output logic                 wptr_adv,
    output logic [PTR_WIDTH-1:0] rd_count,
    output logic                 almost_empty,
    output logic                 ovf_err
);

    localparam int unsigned          DEPTH   = depth_of(PTR_WIDTH);
    localparam logic [PTR_WIDTH-1:0] DEPTH_V = PTR_WIDTH'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] AE_V    = PTR_WIDTH'(AE_THRESHOLD);

    logic [PTR_WIDTH-1:0] b_wptr_next;
    logic [PTR_WIDTH-1:0] diff;
    logic [PTR_WIDTH-1:0] count_next;
    logic                 ovf_cond;

    afifo_sync #(
        .WIDTH  (PTR_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clock (read_clock),
        .reset (read_reset),
        .d     (g_wptr),
        .q     (g_wptr_sync)
    );

    // Decode the synchronized Gray pointer with the shared helper, then size it back to PTR_WIDTH.
    assign b_wptr_next = PTR_WIDTH'(gray2bin(CODE_W'(g_wptr_sync)));

    // Modulo subtraction covers wrap: differing MSBs still give the right distance.
    // Anything beyond DEPTH is impossible for a healthy FIFO, so clamp it and flag it.
    always_comb begin
        diff       = b_wptr_sync - b_rptr;
        ovf_cond   = (diff > DEPTH_V);
        count_next = ovf_cond ? DEPTH_V : diff;
    end

    // Register the decoded pointer. wptr_adv pulses on the edge that loads a new value,
    // so a multi-step jump still gives a single pulse.
    always_ff @(posedge read_clock or negedge read_reset) begin
        if (!read_reset) begin
            b_wptr_sync <= '0;
            wptr_adv    <= 1'b0;
        end else begin
            b_wptr_sync <= b_wptr_next;
            wptr_adv    <= (b_wptr_next != b_wptr_sync);
        end
    end

    // Register occupancy and almost_empty together from the saturated count.
    always_ff @(posedge read_clock or negedge read_reset) begin
        if (!read_reset) begin
            rd_count     <= '0;
            almost_empty <= 1'b1;
        end else begin
            rd_count     <= count_next;
            almost_empty <= (count_next <= AE_V);
        end
    end

    // Sticky overflow: set wins, so err_clear only takes effect while the condition is false.
    always_ff @(posedge read_clock or negedge read_reset) begin
        if (!read_reset) begin
            ovf_err <= 1'b0;
        end else if (ovf_cond) begin
            ovf_err <= 1'b1;
        end else if (err_clear) begin
            ovf_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rd_wptr_sync_decode.sv
// Purpose: directed self-checking bench for rd_wptr_sync_decode (PTR_WIDTH=4, SYNC_STAGES=2, AE_THRESHOLD=1).
// Latency: inputs driven 1 ns after a rising edge, outputs sampled 1 ns after the next ones.
// Backpressure: not applicable.
module tb_rd_wptr_sync_decode;

    logic       read_clock;
    logic       read_reset;
    logic [3:0] g_wptr;
    logic [3:0] b_rptr;
    logic       err_clear;
    logic [3:0] g_wptr_sync;
    logic [3:0] b_wptr_sync;
    logic       wptr_adv;
    logic [3:0] rd_count;
    logic       almost_empty;
    logic       ovf_err;

    int tests;
    int fails;

    rd_wptr_sync_decode #(
        .PTR_WIDTH    (4),
        .SYNC_STAGES  (2),
        .AE_THRESHOLD (1)
    ) dut (
        .read_clock   (read_clock),
        .read_reset   (read_reset),
        .g_wptr       (g_wptr),
        .b_rptr       (b_rptr),
        .err_clear    (err_clear),
        .g_wptr_sync  (g_wptr_sync),
        .b_wptr_sync  (b_wptr_sync),
        .wptr_adv     (wptr_adv),
        .rd_count     (rd_count),
        .almost_empty (almost_empty),
        .ovf_err      (ovf_err)
    );

    initial begin
        read_clock = 1'b0;
        forever #5 read_clock = ~read_clock;
    end

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge read_clock);
        #1;
    endtask

    task automatic test_reset();
        read_reset = 1'b0;
        g_wptr     = 4'b0110;
        b_rptr     = 4'd0;
        err_clear  = 1'b0;
        step(3);
        tests++; if (g_wptr_sync !== 4'd0) begin fails++; $display("FAIL rst_gsync got %b want 0000", g_wptr_sync); end
        tests++; if (b_wptr_sync !== 4'd0) begin fails++; $display("FAIL rst_bsync got %0d want 0", b_wptr_sync); end
        tests++; if (wptr_adv !== 1'b0) begin fails++; $display("FAIL rst_adv got %b want 0", wptr_adv); end
        tests++; if (rd_count !== 4'd0) begin fails++; $display("FAIL rst_count got %0d want 0", rd_count); end
        tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL rst_ae got %b want 1", almost_empty); end
        tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL rst_ovf got %b want 0", ovf_err); end
        read_reset = 1'b1;
        step(1);
        tests++; if (g_wptr_sync !== 4'd0) begin fails++; $display("FAIL rel_e1_gsync got %b want 0000", g_wptr_sync); end
        step(1);
        tests++; if (g_wptr_sync !== 4'b0110) begin fails++; $display("FAIL rel_e2_gsync got %b want 0110", g_wptr_sync); end
        tests++; if (b_wptr_sync !== 4'd0) begin fails++; $display("FAIL rel_e2_bsync got %0d want 0", b_wptr_sync); end
        step(1);
        tests++; if (b_wptr_sync !== 4'd4) begin fails++; $display("FAIL rel_e3_bsync got %0d want 4", b_wptr_sync); end
        tests++; if (wptr_adv !== 1'b1) begin fails++; $display("FAIL rel_e3_adv got %b want 1", wptr_adv); end
        step(1);
        tests++; if (rd_count !== 4'd4) begin fails++; $display("FAIL rel_e4_count got %0d want 4", rd_count); end
        tests++; if (almost_empty !== 1'b0) begin fails++; $display("FAIL rel_e4_ae got %b want 0", almost_empty); end
        tests++; if (wptr_adv !== 1'b0) begin fails++; $display("FAIL rel_e4_adv got %b want 0", wptr_adv); end
    endtask

    task automatic test_single_step();
        g_wptr = 4'b0000;
        b_rptr = 4'd0;
        step(6);
        tests++; if (rd_count !== 4'd0) begin fails++; $display("FAIL step_idle_count got %0d want 0", rd_count); end
        g_wptr = 4'b0001;
        step(1);
        tests++; if (g_wptr_sync !== 4'b0000) begin fails++; $display("FAIL step_e0_gsync got %b want 0000", g_wptr_sync); end
        step(1);
        tests++; if (g_wptr_sync !== 4'b0001) begin fails++; $display("FAIL step_e1_gsync got %b want 0001", g_wptr_sync); end
        step(1);
        tests++; if (b_wptr_sync !== 4'd1) begin fails++; $display("FAIL step_e2_bsync got %0d want 1", b_wptr_sync); end
        tests++; if (wptr_adv !== 1'b1) begin fails++; $display("FAIL step_e2_adv got %b want 1", wptr_adv); end
        step(1);
        tests++; if (rd_count !== 4'd1) begin fails++; $display("FAIL step_e3_count got %0d want 1", rd_count); end
        tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL step_e3_ae got %b want 1", almost_empty); end
        tests++; if (wptr_adv !== 1'b0) begin fails++; $display("FAIL step_e3_adv got %b want 0", wptr_adv); end
    endtask

    task automatic test_level_threshold();
        g_wptr = 4'b0111;
        b_rptr = 4'd1;
        step(6);
        tests++; if (b_wptr_sync !== 4'd5) begin fails++; $display("FAIL lvl_bsync got %0d want 5", b_wptr_sync); end
        tests++; if (rd_count !== 4'd4) begin fails++; $display("FAIL lvl_count got %0d want 4", rd_count); end
        tests++; if (almost_empty !== 1'b0) begin fails++; $display("FAIL lvl_ae got %b want 0", almost_empty); end
        b_rptr = 4'd4;
        step(1);
        tests++; if (rd_count !== 4'd1) begin fails++; $display("FAIL lvl_rd4_count got %0d want 1", rd_count); end
        tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL lvl_rd4_ae got %b want 1", almost_empty); end
    endtask

    task automatic test_wrap();
        g_wptr = 4'b0001;
        b_rptr = 4'd13;
        step(6);
        tests++; if (rd_count !== 4'd4) begin fails++; $display("FAIL wrap_count got %0d want 4", rd_count); end
        tests++; if (almost_empty !== 1'b0) begin fails++; $display("FAIL wrap_ae got %b want 0", almost_empty); end
        tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL wrap_ovf got %b want 0", ovf_err); end
    endtask

    task automatic test_overflow();
        g_wptr = 4'b1111;
        b_rptr = 4'd0;
        step(6);
        tests++; if (b_wptr_sync !== 4'd10) begin fails++; $display("FAIL ovf_bsync got %0d want 10", b_wptr_sync); end
        tests++; if (rd_count !== 4'd8) begin fails++; $display("FAIL ovf_count got %0d want 8", rd_count); end
        tests++; if (ovf_err !== 1'b1) begin fails++; $display("FAIL ovf_set got %b want 1", ovf_err); end
        err_clear = 1'b1;
        step(2);
        tests++; if (ovf_err !== 1'b1) begin fails++; $display("FAIL ovf_clr_blocked got %b want 1", ovf_err); end
        err_clear = 1'b0;
        b_rptr    = 4'd4;
        step(1);
        tests++; if (rd_count !== 4'd6) begin fails++; $display("FAIL ovf_diff6_count got %0d want 6", rd_count); end
        tests++; if (ovf_err !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", ovf_err); end
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL ovf_cleared got %b want 0", ovf_err); end
    endtask

    task automatic test_async_reset();
        int pulses;
        g_wptr = 4'b0111;
        b_rptr = 4'd1;
        step(6);
        tests++; if (rd_count !== 4'd4) begin fails++; $display("FAIL arst_pre_count got %0d want 4", rd_count); end
        #2;
        read_reset = 1'b0;
        #1;
        tests++; if (g_wptr_sync !== 4'd0) begin fails++; $display("FAIL arst_gsync got %b want 0000", g_wptr_sync); end
        tests++; if (b_wptr_sync !== 4'd0) begin fails++; $display("FAIL arst_bsync got %0d want 0", b_wptr_sync); end
        tests++; if (rd_count !== 4'd0) begin fails++; $display("FAIL arst_count got %0d want 0", rd_count); end
        tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL arst_ae got %b want 1", almost_empty); end
        tests++; if (wptr_adv !== 1'b0) begin fails++; $display("FAIL arst_adv got %b want 0", wptr_adv); end
        tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL arst_ovf got %b want 0", ovf_err); end
        step(1);
        read_reset = 1'b1;
        pulses = 0;
        step(1);
        pulses += int'(wptr_adv);
        step(1);
        pulses += int'(wptr_adv);
        step(1);
        pulses += int'(wptr_adv);
        tests++; if (b_wptr_sync !== 4'd5) begin fails++; $display("FAIL arst_rel_bsync got %0d want 5", b_wptr_sync); end
        step(1);
        pulses += int'(wptr_adv);
        tests++; if (rd_count !== 4'd4) begin fails++; $display("FAIL arst_rel_count got %0d want 4", rd_count); end
        tests++; if (almost_empty !== 1'b0) begin fails++; $display("FAIL arst_rel_ae got %b want 0", almost_empty); end
        step(2);
        pulses += int'(wptr_adv);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL arst_rel_pulses got %0d want 1", pulses); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_step();
        test_level_threshold();
        test_wrap();
        test_overflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
